// File: rtl/matrix_vector_stream.sv
// matrix_vector_stream: streaming, fully pipelined NxN matrix x Nx1 vector multiplier.
// Holds one matrix register (identity after reset) that is reloaded with m_load.
// Accepts one vector per cycle over valid/ready and returns one result per cycle
// with a fixed latency of 3 + $clog2(N) cycles. out_ready=0 stalls the whole pipeline.
//
// Ports (all logic is on posedge clk_in, rst_in is synchronous active-high):
//   m_load/m_in/m_ready       matrix load, m_in[row][col], taken when m_ready
//   in_valid/in_vec/in_ready  input vector beat, in_vec[row]
//   out_valid/out_vec/out_ready/out_ovf  result beat with per-row overflow flags
//   busy                      any valid beat in the pipeline or output register
// Elements are two's complement; packed ports are reinterpreted with $signed per element.
//
// Configuration macro: MVM_SATURATE_EN
//   defined   : an out-of-range row is clamped to the signed WIDTH limits
//   undefined : an out-of-range row keeps its low WIDTH bits (wraps)
//   out_ovf is set for an out-of-range row in both builds.
module matrix_vector_stream #(
  parameter int unsigned N           = 4,
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned FIXED_POINT = 1,
  parameter int unsigned FRAC_BITS   = 16
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic                           m_load,
  input  logic [N-1:0][N-1:0][WIDTH-1:0] m_in,
  output logic                           m_ready,
  input  logic                           in_valid,
  input  logic [N-1:0][WIDTH-1:0]        in_vec,
  output logic                           in_ready,
  output logic                           out_valid,
  output logic [N-1:0][WIDTH-1:0]        out_vec,
  input  logic                           out_ready,
  output logic [N-1:0]                   out_ovf,
  output logic                           busy
);

  localparam int unsigned LVLS  = $clog2(N);
  localparam int unsigned SW    = 2 * WIDTH + LVLS;
  localparam int unsigned SHIFT = (FIXED_POINT != 0) ? FRAC_BITS : 0;
  localparam int unsigned HALF  = N / 2;
  localparam bit          ODD   = (N % 2) != 0;
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1} << SHIFT;
`ifdef MVM_SATURATE_EN
  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
`endif

  logic [N-1:0][N-1:0][WIDTH-1:0] mat;
  logic                           s1_valid;
  logic [N-1:0][WIDTH-1:0]        s1_vec;
  // lv_valid[0] qualifies the product stage, lv_valid[k] adder-tree level k
  logic [LVLS:0]                  lv_valid;
  logic signed [SW-1:0]           tree [LVLS+1][N][N];
  logic signed [SW-1:0]           prod [N][N];
  logic signed [SW-1:0]           shifted [N];
  logic [N-1:0][WIDTH-1:0]        res;
  logic [N-1:0]                   res_ovf;
  logic                           stall;

  // Whole pipeline freezes only when a finished result is not taken
  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;
  assign m_ready  = !stall;
  assign busy     = s1_valid || (|lv_valid) || out_valid;

  // Full-precision products, sign-extended to the tree width
  always_comb begin
    prod = '{default: '0};
    for (int unsigned r = 0; r < N; r++) begin
      for (int unsigned c = 0; c < N; c++) begin
        prod[r][c] = SW'($signed(mat[r][c])) * SW'($signed(s1_vec[c]));
      end
    end
  end

  // Row result: one shift after the full sum, then range check and wrap/clamp
  always_comb begin
    shifted = '{default: '0};
    res     = '0;
    res_ovf = '0;
    for (int unsigned r = 0; r < N; r++) begin
      shifted[r] = tree[LVLS][r][0] >>> SHIFT;
      res_ovf[r] = shifted[r][SW-1:WIDTH-1] != {(SW-WIDTH+1){shifted[r][WIDTH-1]}};
`ifdef MVM_SATURATE_EN
      res[r] = res_ovf[r] ? (shifted[r][SW-1] ? SMIN : SMAX) : shifted[r][WIDTH-1:0];
`else
      res[r] = shifted[r][WIDTH-1:0];
`endif
    end
  end

  // Matrix register, pipeline stages and output register
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      s1_valid  <= 1'b0;
      lv_valid  <= '0;
      out_valid <= 1'b0;
      out_vec   <= '0;
      out_ovf   <= '0;
      for (int unsigned r = 0; r < N; r++) begin
        for (int unsigned c = 0; c < N; c++) begin
          mat[r][c] <= (r == c) ? ONE : '0;
        end
      end
    end else if (!stall) begin
      // A load lands before the S1 beat reaches the product stage, so a
      // vector accepted alongside the load sees the new matrix
      if (m_load) begin
        mat <= m_in;
      end
      s1_valid <= in_valid;
      s1_vec   <= in_vec;
      lv_valid <= {lv_valid[LVLS-1:0], s1_valid};
      tree[0]  <= prod;
      // Pairwise tree; slots past the live width carry zero
      for (int unsigned lv = 1; lv <= LVLS; lv++) begin
        for (int unsigned r = 0; r < N; r++) begin
          for (int unsigned i = 0; i < N; i++) begin
            if (i < HALF) begin
              tree[lv][r][i] <= tree[lv-1][r][2*i] + tree[lv-1][r][2*i+1];
            end else if (ODD && (i == HALF)) begin
              tree[lv][r][i] <= tree[lv-1][r][N-1];
            end else begin
              tree[lv][r][i] <= '0;
            end
          end
        end
      end
      out_valid <= lv_valid[LVLS];
      out_vec   <= res;
      out_ovf   <= res_ovf;
    end
  end

endmodule

// File: tb/tb_matrix_vector_stream.sv
// Directed bench for matrix_vector_stream (N=4, WIDTH=32, Q16.16).
module tb_matrix_vector_stream;

  typedef logic [3:0][31:0]      vec_t;
  typedef logic [3:0][3:0][31:0] mat_t;
  typedef struct packed {
    logic [3:0] ovf;
    vec_t       vec;
  } beat_t;

  logic clk = 1'b0;
  logic rst_in, m_load, m_ready, in_valid, in_ready, out_valid, out_ready, busy;
  mat_t m_in;
  vec_t in_vec, out_vec;
  logic [3:0] out_ovf;

  matrix_vector_stream #(.N(4), .WIDTH(32), .FIXED_POINT(1), .FRAC_BITS(16)) dut (
    .clk_in(clk), .rst_in(rst_in), .m_load(m_load), .m_in(m_in), .m_ready(m_ready),
    .in_valid(in_valid), .in_vec(in_vec), .in_ready(in_ready),
    .out_valid(out_valid), .out_vec(out_vec), .out_ready(out_ready),
    .out_ovf(out_ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc_cnt = 0;
  beat_t got_q[$];
  beat_t exp_q[$];
  int    got_cyc[$];
  mat_t  cur_m;
  mat_t  m_ident, m_tr, m_alt, m_ovf;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Capture every delivered result beat mid-cycle
  always @(negedge clk) begin
    beat_t b;
    if (!rst_in && out_valid && out_ready) begin
      b.ovf = out_ovf;
      b.vec = out_vec;
      got_q.push_back(b);
      got_cyc.push_back(cyc_cnt);
    end
  end

  task automatic check(input string tag, input logic [135:0] got, input logic [135:0] expv);
    n_tests++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, expv);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mkvec(input int k);
    vec_t v;
    v[0] = 32'((k + 1) * 65536);
    v[1] = 32'(-(k * 32768));
    v[2] = 32'h0002_0000;
    v[3] = 32'(k * 16384);
    return v;
  endfunction

  // Reference: 64-bit accumulate, floor shift by 16, range check on 32 bits
  function automatic beat_t ref_mv(input mat_t m, input vec_t v);
    beat_t  b;
    longint acc;
    for (int r = 0; r < 4; r++) begin
      acc = 0;
      for (int c = 0; c < 4; c++) acc += longint'($signed(m[r][c])) * longint'($signed(v[c]));
      acc = acc >>> 16;
      b.ovf[r] = (acc > 64'sd2147483647) || (acc < -64'sd2147483648);
`ifdef MVM_SATURATE_EN
      if (b.ovf[r]) b.vec[r] = (acc < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
      else b.vec[r] = acc[31:0];
`else
      b.vec[r] = acc[31:0];
`endif
    end
    return b;
  endfunction

  task automatic do_reset();
    rst_in = 1'b1; m_load = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    m_in = '0; in_vec = '0;
    cycle();
    cycle();
    rst_in = 1'b0;
    cur_m = m_ident;
  endtask

  // One beat into an idle pipe, optionally with a same-cycle matrix load
  task automatic single_beat(input mat_t m, input logic ld, input vec_t v,
                             output beat_t ob, output int lat);
    m_in = m; m_load = ld; in_valid = 1'b1; in_vec = v; out_ready = 1'b1;
    cycle();
    m_load = 1'b0; in_valid = 1'b0; lat = 1;
    while (!out_valid && lat < 20) begin
      cycle();
      lat++;
    end
    ob.vec = out_vec;
    ob.ovf = out_ovf;
    if (ld) cur_m = m;
    cycle();
    got_q.delete();
    got_cyc.delete();
  endtask

  // nb beats from mkvec(base+k); out_ready low for stall_len cycles from stall_at;
  // matrix new_m loaded together with beat mload_at (-1: none)
  task automatic run_stream(input int nb, input int base, input int stall_at,
                            input int stall_len, input int mload_at, input mat_t new_m);
    int   k = 0;
    int   c = 0;
    logic prev_stall = 1'b0;
    vec_t held = '0;
    while ((k < nb || busy) && c < 200) begin
      out_ready = !(c >= stall_at && c < stall_at + stall_len);
      in_valid  = (k < nb);
      in_vec    = mkvec(base + k);
      m_in      = new_m;
      m_load    = in_valid && (k == mload_at);
      #1;
      if (prev_stall) check("stall_hold_vec", out_vec, held);
      if (out_valid && !out_ready) begin
        check("stall_in_ready", in_ready, 0);
        check("stall_m_ready", m_ready, 0);
        held = out_vec;
        prev_stall = 1'b1;
      end else begin
        prev_stall = 1'b0;
      end
      if (in_valid && in_ready) begin
        if (m_load) cur_m = new_m;
        exp_q.push_back(ref_mv(cur_m, in_vec));
        k++;
      end
      cycle();
      c++;
    end
    if (c >= 200) check("stream_timeout", 1, 0);
    in_valid = 1'b0; m_load = 1'b0; out_ready = 1'b1;
  endtask

  task automatic compare_queues(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s_beat%0d", tag, i), got_q[i], exp_q[i]);
  endtask

  task automatic clear_queues();
    got_q.delete();
    exp_q.delete();
    got_cyc.delete();
  endtask

  initial begin
    beat_t ob;
    int    lat;
    vec_t  v, e;
    int    stale;

    m_ident = '0; m_tr = '0; m_alt = '0; m_ovf = '0;
    for (int i = 0; i < 4; i++) begin
      m_ident[i][i] = 32'h0001_0000;
      m_tr[i][i]    = (i == 3) ? 32'h0001_0000 : 32'h0002_0000;
      m_alt[i][i]   = 32'h0003_0000;
      m_ovf[i][i]   = 32'h7FFF_0000;
    end
    m_tr[0][3] = 32'h0001_0000;
    m_tr[1][3] = 32'h0002_0000;
    m_tr[2][3] = 32'h0003_0000;
    for (int i = 1; i < 4; i++) m_alt[i][0] = 32'h0000_8000;

    do_reset();
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out_vec", out_vec, 0);
    check("rst_out_ovf", out_ovf, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_m_ready", m_ready, 1);

    // Identity after reset: {1.0, 2.0, -3.0, 0.5} returns unchanged after 5 cycles
    v[0] = 32'h0001_0000; v[1] = 32'h0002_0000; v[2] = 32'hFFFD_0000; v[3] = 32'h0000_8000;
    single_beat(m_ident, 1'b0, v, ob, lat);
    check("ident_latency", lat, 5);
    check("ident_vec", ob.vec, v);
    check("ident_ovf", ob.ovf, 0);

    // diag(2,2,2,1) with col3 = (1,2,3), loaded with the beat: (1,1,1,1) -> (3,4,5,1)
    v = {4{32'h0001_0000}};
    e[0] = 32'h0003_0000; e[1] = 32'h0004_0000; e[2] = 32'h0005_0000; e[3] = 32'h0001_0000;
    single_beat(m_tr, 1'b1, v, ob, lat);
    check("translate_latency", lat, 5);
    check("translate_vec", ob.vec, e);
    check("translate_ovf", ob.ovf, 0);

    // 8 back-to-back beats: in order, one result per cycle
    run_stream(8, 0, 1000, 0, -1, m_tr);
    compare_queues("b2b");
    if (got_cyc.size() == 8) check("b2b_gapless", got_cyc[7] - got_cyc[0], 7);
    clear_queues();

    // out_ready low for 3 cycles while results are waiting
    run_stream(8, 10, 6, 3, -1, m_tr);
    compare_queues("stall");
    clear_queues();

    // Matrix switch with beat 3: beats 0..2 use m_tr, beats 3..5 use m_alt
    run_stream(6, 20, 1000, 0, 3, m_alt);
    compare_queues("mswitch");
    clear_queues();

    // diag(32767.0) x 2.0 = 65534.0 on every row: out of Q16.16 range
    v = {4{32'h0002_0000}};
`ifdef MVM_SATURATE_EN
    e = {4{32'h7FFF_FFFF}};
`else
    e = {4{32'hFFFE_0000}};
`endif
    single_beat(m_ovf, 1'b1, v, ob, lat);
    check("ovf_flags", ob.ovf, 4'hF);
    check("ovf_vec", ob.vec, e);

    // Reset with 3 beats in flight: nothing may emerge afterwards
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_vec = mkvec(40 + i);
      cycle();
    end
    in_valid = 1'b0;
    rst_in = 1'b1;
    cycle();
    rst_in = 1'b0;
    cur_m = m_ident;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    stale = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) stale++;
      cycle();
    end
    check("midrst_no_stale", stale, 0);
    check("midrst_no_capture", got_q.size(), 0);
    clear_queues();

    // Matrix register back to identity after the reset
    v = mkvec(5);
    single_beat(m_ident, 1'b0, v, ob, lat);
    check("post_rst_latency", lat, 5);
    check("post_rst_vec", ob.vec, v);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
